// File: rtl/approx_adder_error_monitor_if.sv
// Sample and statistics-record ports of the approximate-adder error monitor.
// The producer/consumer side uses master; the monitor uses slave.
interface approx_adder_error_monitor_if #(
    parameter int BIT_WIDTH = 8,
    parameter int ACC_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic [BIT_WIDTH:0]   approx_sum;
    logic                 flush;
    logic                 stat_valid;
    logic                 stat_ready;
    logic [ACC_WIDTH-1:0] sample_count;
    logic [ACC_WIDTH-1:0] err_count;
    logic [ACC_WIDTH-1:0] err_abs_sum;
    logic [ACC_WIDTH-1:0] err_signed_sum;
    logic [BIT_WIDTH:0]   err_max;

    modport master (
        output in_valid, a, b, approx_sum, flush, stat_ready,
        input  in_ready, stat_valid, sample_count, err_count,
        input  err_abs_sum, err_signed_sum, err_max
    );

    modport slave (
        input  in_valid, a, b, approx_sum, flush, stat_ready,
        output in_ready, stat_valid, sample_count, err_count,
        output err_abs_sum, err_signed_sum, err_max
    );
endinterface

// File: rtl/approx_adder_error_monitor.sv
// Error monitor for approximate adders: recomputes exact sums and
// accumulates per-window error statistics, reported over valid/ready.
module approx_adder_error_monitor #(
    parameter int BIT_WIDTH = 8,
    parameter int WINDOW    = 256,
    parameter int ACC_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    approx_adder_error_monitor_if.slave bus
);
    localparam int EW = BIT_WIDTH + 2;

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] DRAIN   = 2'd1;
    localparam logic [1:0] REPORT  = 2'd2;

    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] LAST = ACC_WIDTH'(WINDOW - 1);

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] win_cnt;
    logic                 accept;
    logic                 leave;

    logic [BIT_WIDTH:0]    exact;
    logic signed [EW-1:0]  err;
    logic [BIT_WIDTH:0]    abs_err;

    logic                  s1_valid;
    logic signed [EW-1:0]  s1_err;
    logic [BIT_WIDTH:0]    s1_abs;

    logic [ACC_WIDTH-1:0] acc_cnt, acc_err, acc_abs, acc_sgn;
    logic [BIT_WIDTH:0]   acc_max;
    logic [ACC_WIDTH-1:0] nxt_cnt, nxt_err, nxt_abs, nxt_sgn;
    logic [BIT_WIDTH:0]   nxt_max;
    logic [ACC_WIDTH:0]   abs_wide;
    logic [ACC_WIDTH-1:0] e_ext;
    logic [ACC_WIDTH-1:0] sgn_sum;
    logic                 sgn_ovf;

    assign bus.in_ready   = (state == COLLECT);
    assign bus.stat_valid = (state == REPORT);

    assign accept = bus.in_valid & bus.in_ready;
    assign leave  = (accept && (win_cnt == LAST)) ||
                    (bus.flush && bus.in_ready && (accept || win_cnt != '0));

    // Exact sum and signed/absolute error of the incoming sample.
    always_comb begin
        exact   = {1'b0, bus.a} + {1'b0, bus.b};
        err     = $signed({1'b0, exact}) - $signed({1'b0, bus.approx_sum});
        abs_err = err[EW-1] ? (BIT_WIDTH+1)'(-err) : (BIT_WIDTH+1)'(err);
    end

    // Next accumulator values with saturation on both error sums.
    always_comb begin
        nxt_cnt  = acc_cnt;
        nxt_err  = acc_err;
        nxt_abs  = acc_abs;
        nxt_sgn  = acc_sgn;
        nxt_max  = acc_max;
        abs_wide = {1'b0, acc_abs} + (ACC_WIDTH+1)'(s1_abs);
        e_ext    = ACC_WIDTH'(s1_err);
        sgn_sum  = acc_sgn + e_ext;
        sgn_ovf  = (acc_sgn[ACC_WIDTH-1] == e_ext[ACC_WIDTH-1]) &&
                   (sgn_sum[ACC_WIDTH-1] != acc_sgn[ACC_WIDTH-1]);
        if (s1_valid) begin
            nxt_cnt = acc_cnt + 1'b1;
            nxt_err = acc_err + ACC_WIDTH'(s1_err != '0);
            nxt_abs = abs_wide[ACC_WIDTH] ? '1 : abs_wide[ACC_WIDTH-1:0];
            if (sgn_ovf)
                nxt_sgn = acc_sgn[ACC_WIDTH-1] ? SMIN : SMAX;
            else
                nxt_sgn = sgn_sum;
            if (s1_abs >= acc_max)
                nxt_max = s1_abs;
        end
    end

    // Window control: collect samples, drain the pipe, hold the record.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= COLLECT;
            win_cnt <= '0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (leave) begin
                        state   <= DRAIN;
                        win_cnt <= '0;
                    end else if (accept) begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                DRAIN:   state <= REPORT;
                REPORT:  if (bus.stat_ready) state <= COLLECT;
                default: state <= COLLECT;
            endcase
        end
    end

    // Stage 1: register the per-sample error.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= '0;
            s1_abs   <= '0;
        end else begin
            s1_valid <= accept;
            s1_err   <= err;
            s1_abs   <= abs_err;
        end
    end

    // Stage 2: accumulate; cleared when the record is taken.
    always_ff @(posedge clk) begin
        if (rst || (state == REPORT && bus.stat_ready)) begin
            acc_cnt <= '0;
            acc_err <= '0;
            acc_abs <= '0;
            acc_sgn <= '0;
            acc_max <= '0;
        end else begin
            acc_cnt <= nxt_cnt;
            acc_err <= nxt_err;
            acc_abs <= nxt_abs;
            acc_sgn <= nxt_sgn;
            acc_max <= nxt_max;
        end
    end

    // Snapshot the final totals, including the last drained sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sample_count   <= '0;
            bus.err_count      <= '0;
            bus.err_abs_sum    <= '0;
            bus.err_signed_sum <= '0;
            bus.err_max        <= '0;
        end else if (state == DRAIN) begin
            bus.sample_count   <= nxt_cnt;
            bus.err_count      <= nxt_err;
            bus.err_abs_sum    <= nxt_abs;
            bus.err_signed_sum <= nxt_sgn;
            bus.err_max        <= nxt_max;
        end
    end
endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Bench for approx_adder_error_monitor: two instances (32- and 10-bit
// accumulators), scoreboard of expected records checked on each report.
module tb_approx_adder_error_monitor;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    approx_adder_error_monitor_if #(.BIT_WIDTH(8), .ACC_WIDTH(32)) if0 ();
    approx_adder_error_monitor_if #(.BIT_WIDTH(8), .ACC_WIDTH(10)) if1 ();

    approx_adder_error_monitor #(.BIT_WIDTH(8), .WINDOW(4), .ACC_WIDTH(32))
        dut0 (.clk(clk), .rst(rst0), .bus(if0));
    approx_adder_error_monitor #(.BIT_WIDTH(8), .WINDOW(4), .ACC_WIDTH(10))
        dut1 (.clk(clk), .rst(rst1), .bus(if1));

    typedef struct {
        longint cnt;
        longint err;
        longint abs_s;
        longint sgn;
        longint max;
    } rec_t;

    rec_t q[$];
    longint m_cnt = 0, m_err = 0, m_abs = 0, m_sgn = 0, m_max = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint rd(input int sel, input int k);
        if (sel == 0) begin
            case (k)
                0: return longint'(if0.in_ready);
                1: return longint'(if0.stat_valid);
                2: return longint'(if0.sample_count);
                3: return longint'(if0.err_count);
                4: return longint'(if0.err_abs_sum);
                5: return longint'($signed(if0.err_signed_sum));
                default: return longint'(if0.err_max);
            endcase
        end
        case (k)
            0: return longint'(if1.in_ready);
            1: return longint'(if1.stat_valid);
            2: return longint'(if1.sample_count);
            3: return longint'(if1.err_count);
            4: return longint'(if1.err_abs_sum);
            5: return longint'($signed(if1.err_signed_sum));
            default: return longint'(if1.err_max);
        endcase
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_err = 0; m_abs = 0; m_sgn = 0; m_max = 0;
    endtask

    task automatic push_rec();
        rec_t r;
        r.cnt = m_cnt; r.err = m_err; r.abs_s = m_abs;
        r.sgn = m_sgn; r.max = m_max;
        q.push_back(r);
        model_clear();
    endtask

    task automatic model_add(input logic [7:0] a, input logic [7:0] b,
                             input logic [8:0] ap, input int acc);
        longint e, ae, lim, smax, smin;
        e = longint'(a) + longint'(b) - longint'(ap);
        ae = (e < 0) ? -e : e;
        lim = (longint'(1) << acc) - 1;
        smax = (longint'(1) << (acc - 1)) - 1;
        smin = -(longint'(1) << (acc - 1));
        m_cnt++;
        if (e != 0) m_err++;
        m_abs = (m_abs + ae > lim) ? lim : m_abs + ae;
        m_sgn = m_sgn + e;
        if (m_sgn > smax) m_sgn = smax;
        if (m_sgn < smin) m_sgn = smin;
        if (ae > m_max) m_max = ae;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [8:0] ap,
                         input logic fl);
        if (sel == 0) begin
            if0.in_valid = v; if0.a = a; if0.b = b;
            if0.approx_sum = ap; if0.flush = fl;
        end else begin
            if1.in_valid = v; if1.a = a; if1.b = b;
            if1.approx_sum = ap; if1.flush = fl;
        end
    endtask

    task automatic set_ready(input int sel, input logic r);
        if (sel == 0) if0.stat_ready = r;
        else if1.stat_ready = r;
    endtask

    task automatic send(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] ap, input logic fl, input int acc);
        chk("in_ready_before_accept", rd(sel, 0), 1);
        drive(sel, 1'b1, a, b, ap, fl);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 8'h00, 8'h00, 9'h000, 1'b0);
        model_add(a, b, ap, acc);
        if (m_cnt == 4 || fl) push_rec();
    endtask

    task automatic flush_only(input int sel);
        drive(sel, 1'b0, 8'h00, 8'h00, 9'h000, 1'b1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 8'h00, 8'h00, 9'h000, 1'b0);
        if (m_cnt > 0) push_rec();
    endtask

    task automatic take(input int sel);
        rec_t r;
        int w = 0;
        while (rd(sel, 1) != 1 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("stat_valid_wait", rd(sel, 1), 1);
        if (q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            r = q.pop_front();
            chk("sample_count", rd(sel, 2), r.cnt);
            chk("err_count", rd(sel, 3), r.err);
            chk("err_abs_sum", rd(sel, 4), r.abs_s);
            chk("err_signed_sum", rd(sel, 5), r.sgn);
            chk("err_max", rd(sel, 6), r.max);
        end
        set_ready(sel, 1'b1);
        @(posedge clk);
        #1;
        set_ready(sel, 1'b0);
        chk("in_ready_after_take", rd(sel, 0), 1);
        chk("stat_valid_after_take", rd(sel, 1), 0);
    endtask

    initial begin
        drive(0, 1'b0, 8'h00, 8'h00, 9'h000, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 9'h000, 1'b0);
        set_ready(0, 1'b0);
        set_ready(1, 1'b0);
        idle(2);
        rst0 = 1'b0;
        rst1 = 1'b0;
        idle(1);

        chk("rst_in_ready", rd(0, 0), 1);
        chk("rst_stat_valid", rd(0, 1), 0);
        chk("rst_sample_count", rd(0, 2), 0);
        chk("rst_err_count", rd(0, 3), 0);
        chk("rst_err_abs_sum", rd(0, 4), 0);
        chk("rst_err_signed_sum", rd(0, 5), 0);
        chk("rst_err_max", rd(0, 6), 0);

        for (int i = 0; i < 4; i++) send(0, 8'h0F, 8'h01, 9'h00F, 1'b0, 32);
        chk("latency_n1_not_valid", rd(0, 1), 0);
        chk("latency_n1_in_ready", rd(0, 0), 0);
        idle(1);
        chk("latency_n2_valid", rd(0, 1), 1);
        take(0);
        chk("hold_after_take", rd(0, 3), 4);

        for (int i = 0; i < 4; i++) send(0, 8'hFF, 8'hFF, 9'h1FE, 1'b0, 32);
        take(0);

        send(0, 8'h00, 8'h00, 9'h1FF, 1'b0, 32);
        send(0, 8'h00, 8'h00, 9'h1FF, 1'b1, 32);
        take(0);

        set_ready(0, 1'b1);
        flush_only(0);
        idle(2);
        set_ready(0, 1'b0);
        chk("empty_flush_ignored", rd(0, 1), 0);
        chk("empty_flush_in_ready", rd(0, 0), 1);

        send(0, 8'h80, 8'h80, 9'h0FF, 1'b0, 32);
        flush_only(0);
        idle(1);
        drive(0, 1'b0, 8'h00, 8'h00, 9'h000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_stat_valid", rd(0, 1), 1);
            chk("bp_in_ready", rd(0, 0), 0);
            chk("bp_abs_stable", rd(0, 4), q[0].abs_s);
            idle(1);
        end
        drive(0, 1'b0, 8'h00, 8'h00, 9'h000, 1'b0);
        take(0);

        send(0, 8'h10, 8'h20, 9'h031, 1'b0, 32);
        send(0, 8'h10, 8'h20, 9'h02E, 1'b0, 32);
        send(0, 8'h01, 8'h01, 9'h002, 1'b0, 32);
        send(0, 8'hFF, 8'h00, 9'h0F0, 1'b0, 32);
        take(0);

        for (int i = 0; i < 3; i++) send(1, 8'h00, 8'h00, 9'h1FF, 1'b0, 10);
        rst1 = 1'b1;
        idle(1);
        rst1 = 1'b0;
        model_clear();
        idle(4);
        chk("midrst_no_record", rd(1, 1), 0);
        chk("midrst_sample_count", rd(1, 2), 0);
        chk("midrst_in_ready", rd(1, 0), 1);

        for (int i = 0; i < 4; i++) send(1, 8'h00, 8'h00, 9'h1FF, 1'b0, 10);
        take(1);
        for (int i = 0; i < 4; i++) send(1, 8'hFF, 8'hFF, 9'h000, 1'b0, 10);
        take(1);

        chk("scoreboard_drained", longint'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
